// File: rtl/param_cmd_fifo_pkg.sv
// Shared sizing helpers and the status bundle consumed by the command executor.
package param_cmd_fifo_pkg;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/param_cmd_fifo_if.sv
// Writer/reader handshake bundle between the input decoder and the command executor.
interface param_cmd_fifo_if
    import param_cmd_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 5,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic              we;
    logic              re;
    logic              del;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output we, re, del, data_in,
        input  data_out, valid_out, empty, full, almost_full, count, overflow, underflow
    );

    modport slave (
        input  we, re, del, data_in,
        output data_out, valid_out, empty, full, almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/param_cmd_fifo_ram.sv
// DEPTH x DATA_W simple dual-port RAM: synchronous write, registered read (read-before-write).
module param_cmd_fifo_ram
    import param_cmd_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 5,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [ptr_w(DEPTH)-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    input  logic [ptr_w(DEPTH)-1:0]  rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Output register only is reset; the array keeps its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/param_cmd_fifo.sv
// Command FIFO control: pointers, occupancy, registered flags, undo/replace of newest entry.
module param_cmd_fifo
    import param_cmd_fifo_pkg::*;
#(
    parameter int unsigned DATA_W       = 5,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AFULL_THRESH = 6
) (
    input logic             clk,
    input logic             rst,
    param_cmd_fifo_if.slave bus
);
    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    generate
        if (!is_pow2(DEPTH) || DEPTH < 2 || AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_params
            $error("param_cmd_fifo: DEPTH must be a power of 2 >= 2 and AFULL_THRESH in 1..DEPTH");
        end
    endgenerate

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q;
    fifo_status_t     status_q, status_d;

    logic             re_ok;
    logic             has_newest;
    logic             wr_plain;
    logic             wr_acc;
    logic             replace;
    logic             del_acc;
    logic             ram_we;
    logic [PTR_W-1:0] ram_waddr;

    // "Newest" must survive a same-edge pop, hence the threshold of 1 when reading.
    always_comb begin
        re_ok      = bus.re & ~status_q.empty;
        has_newest = count_q > CNT_W'(re_ok);
        replace    = bus.we & bus.del & has_newest;
        wr_plain   = bus.we & ~replace;
        wr_acc     = wr_plain & (~status_q.full | re_ok);
        del_acc    = bus.del & ~bus.we & has_newest;
        ram_we     = wr_acc | replace;
        ram_waddr  = replace ? (wr_ptr_q - PTR_W'(1)) : wr_ptr_q;

        rd_ptr_d = rd_ptr_q + PTR_W'(re_ok);
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc) - PTR_W'(del_acc);
        count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(re_ok) - CNT_W'(del_acc);

        status_d             = status_q;
        status_d.empty       = (count_d == '0);
        status_d.full        = (count_d == CNT_W'(DEPTH));
        status_d.almost_full = (count_d >= CNT_W'(AFULL_THRESH));
        status_d.overflow    = status_q.overflow | (wr_plain & status_q.full & ~re_ok);
        status_d.underflow   = status_q.underflow | (status_q.empty & (bus.re | (bus.del & ~bus.we)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            status_q <= '{empty: 1'b1, default: 1'b0};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= re_ok;
            status_q <= status_d;
        end
    end

    param_cmd_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (ram_we & ~rst),
        .wr_addr_i (ram_waddr),
        .wr_data_i (bus.data_in),
        .rd_en_i   (re_ok),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (bus.data_out)
    );

    assign bus.valid_out   = valid_q;
    assign bus.empty       = status_q.empty;
    assign bus.full        = status_q.full;
    assign bus.almost_full = status_q.almost_full;
    assign bus.count       = count_q;
    assign bus.overflow    = status_q.overflow;
    assign bus.underflow   = status_q.underflow;

endmodule
